// File: rtl/sid_filter_ctrl.sv
// sid_filter_ctrl: sample-rate sequencer that commits SID filter registers and fires the filter datapath.
//   clk, rst                   : clock, synchronous active-high reset
//   bus_we/bus_addr/bus_wdata  : register write port; bus_ack pulses one cycle after each write
//   voice1_in..3_in, ext_in_raw: live samples, latched once per sample into voice1..3, ext_in
//   Fc_lo, Fc_hi, Res_Filt, Mode_Vol : active filter configuration
//   input_valid, busy, overrun : filter start pulse, computation in flight, sticky missed tick (cleared by write to 0x1F)
module sid_filter_ctrl #(
    parameter int SAMPLE_DIV  = 32,
    parameter int FILT_CYCLES = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_we,
    input  logic [4:0]  bus_addr,
    input  logic [7:0]  bus_wdata,
    output logic        bus_ack,
    input  logic [11:0] voice1_in,
    input  logic [11:0] voice2_in,
    input  logic [11:0] voice3_in,
    input  logic [11:0] ext_in_raw,
    output logic [11:0] voice1,
    output logic [11:0] voice2,
    output logic [11:0] voice3,
    output logic [11:0] ext_in,
    output logic [7:0]  Fc_lo,
    output logic [7:0]  Fc_hi,
    output logic [7:0]  Res_Filt,
    output logic [7:0]  Mode_Vol,
    output logic        input_valid,
    output logic        busy,
    output logic        overrun
);
    localparam int CW = $clog2(FILT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, COMMIT, FIRE, BUSY} state_t;
    state_t state, state_nx;
    logic [15:0]   div;
    logic          tick;
    logic [CW-1:0] cnt;
    logic [7:0]    shadow [4];
    logic [3:0]    dirty;
    logic          wr_cfg;
    logic [1:0]    wr_idx;
    assign tick   = div == 16'(SAMPLE_DIV - 1);
    assign wr_cfg = bus_we && bus_addr >= 5'h15 && bus_addr <= 5'h18;
    assign wr_idx = 2'(bus_addr - 5'h15);
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= state_nx;
    always_comb begin
        state_nx    = state == IDLE   ? (tick ? COMMIT : IDLE) :
                      state == COMMIT ? FIRE :
                      state == FIRE   ? BUSY :
                      cnt == CW'(1)   ? IDLE : BUSY;
        input_valid = state == FIRE;
        busy        = state == FIRE || state == BUSY;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            div      <= '0;
            cnt      <= '0;
            dirty    <= '0;
            shadow   <= '{default: '0};
            Fc_lo    <= '0;
            Fc_hi    <= '0;
            Res_Filt <= '0;
            Mode_Vol <= '0;
            voice1   <= '0;
            voice2   <= '0;
            voice3   <= '0;
            ext_in   <= '0;
            bus_ack  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            div     <= tick ? '0 : div + 16'd1;
            bus_ack <= bus_we;
            // a dropped tick wins over a simultaneous clear so the event is never lost
            if (tick && state != IDLE)
                overrun <= 1'b1;
            else if (bus_we && bus_addr == 5'h1F)
                overrun <= 1'b0;
            if (state == FIRE)
                cnt <= CW'(FILT_CYCLES);
            else if (state == BUSY)
                cnt <= cnt - CW'(1);
            if (state == COMMIT) begin
                if (dirty[0]) Fc_lo    <= {5'b0, shadow[0][2:0]};
                if (dirty[1]) Fc_hi    <= shadow[1];
                if (dirty[2]) Res_Filt <= shadow[2];
                if (dirty[3]) Mode_Vol <= shadow[3];
                dirty  <= '0;
                voice1 <= voice1_in;
                voice2 <= voice2_in;
                voice3 <= voice3_in;
                ext_in <= ext_in_raw;
            end
            // placed after the commit clear: a write landing in COMMIT keeps its register dirty
            if (wr_cfg) begin
                shadow[wr_idx] <= bus_wdata;
                dirty[wr_idx]  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sid_filter_ctrl.sv
// tb_sid_filter_ctrl: directed bench for sid_filter_ctrl at default and tight (14/13) timing.
module tb_sid_filter_ctrl;
    logic        clk = 1'b0;
    logic        rst, rst2;
    logic        we, we2;
    logic [4:0]  addr, addr2;
    logic [7:0]  wdata, wdata2;
    logic [11:0] v1_in, v2_in, v3_in, ext_raw;
    logic        ack, ack2;
    logic [11:0] v1, v2, v3, ext;
    logic [11:0] v1b, v2b, v3b, extb;
    logic [7:0]  fc_lo, fc_hi, res_filt, mode_vol;
    logic [7:0]  fc_lo2, fc_hi2, res_filt2, mode_vol2;
    logic        iv, bsy, ovr, iv2, bsy2, ovr2;
    int checks = 0, errors = 0, cyc = 0, n;
    always #5 clk = ~clk;
    sid_filter_ctrl dut (
        .clk(clk), .rst(rst), .bus_we(we), .bus_addr(addr), .bus_wdata(wdata), .bus_ack(ack),
        .voice1_in(v1_in), .voice2_in(v2_in), .voice3_in(v3_in), .ext_in_raw(ext_raw),
        .voice1(v1), .voice2(v2), .voice3(v3), .ext_in(ext),
        .Fc_lo(fc_lo), .Fc_hi(fc_hi), .Res_Filt(res_filt), .Mode_Vol(mode_vol),
        .input_valid(iv), .busy(bsy), .overrun(ovr)
    );
    sid_filter_ctrl #(.SAMPLE_DIV(14), .FILT_CYCLES(13)) dut2 (
        .clk(clk), .rst(rst2), .bus_we(we2), .bus_addr(addr2), .bus_wdata(wdata2), .bus_ack(ack2),
        .voice1_in(12'h111), .voice2_in(12'h222), .voice3_in(12'h333), .ext_in_raw(12'h444),
        .voice1(v1b), .voice2(v2b), .voice3(v3b), .ext_in(extb),
        .Fc_lo(fc_lo2), .Fc_hi(fc_hi2), .Res_Filt(res_filt2), .Mode_Vol(mode_vol2),
        .input_valid(iv2), .busy(bsy2), .overrun(ovr2)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask
    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask
    task automatic step_to(input int t);
        if (t > cyc) step(t - cyc);
    endtask
    task automatic wr(input bit b, input logic [4:0] a, input logic [7:0] d);
        if (b) begin we2 = 1'b1; addr2 = a; wdata2 = d; end
        else   begin we  = 1'b1; addr  = a; wdata  = d; end
        step(1);
        check("ack", b ? ack2 : ack, 1);
        we = 1'b0;
        we2 = 1'b0;
    endtask
    initial begin
        rst = 1'b1; rst2 = 1'b1; we = 1'b0; we2 = 1'b0;
        addr = '0; addr2 = '0; wdata = '0; wdata2 = '0;
        v1_in = 12'h123; v2_in = 12'h456; v3_in = 12'h789; ext_raw = 12'hABC;
        step(3);
        check("rst_iv", iv, 0);
        check("rst_busy", bsy, 0);
        check("rst_ovr", ovr, 0);
        check("rst_ack", ack, 0);
        check("rst_v1", v1, 0);
        check("rst_cfg", {fc_lo, fc_hi, res_filt, mode_vol}, 0);
        rst = 1'b0;
        cyc = 0;
        step_to(32);
        check("iv_pre33", iv, 0);
        step_to(33);
        check("iv33", iv, 1);
        check("v1_latch", v1, 12'h123);
        check("ext_latch", ext, 12'hABC);
        n = 0;
        while (bsy && n < 40) begin
            n++;
            step(1);
        end
        check("busy_len", n, 12);
        step_to(64);
        check("iv64", iv, 0);
        step_to(65);
        check("iv65", iv, 1);
        step_to(97);
        check("iv97", iv, 1);
        check("cfg_zero", {fc_lo, fc_hi, res_filt, mode_vol}, 0);
        step_to(110);
        wr(0, 5'h16, 8'hA5);
        wr(0, 5'h15, 8'hFF);
        step(1);
        check("ack_low", ack, 0);
        step_to(128);
        check("fc_pre", {fc_hi, fc_lo}, 0);
        step_to(129);
        check("fc_hi", fc_hi, 8'hA5);
        check("fc_lo", fc_lo, 8'h07);
        step_to(130);
        wr(0, 5'h18, 8'h1F);
        check("mv_busy", mode_vol, 0);
        step_to(160);
        check("mv_pre", mode_vol, 0);
        step_to(161);
        check("mv_commit", mode_vol, 8'h1F);
        step_to(162);
        wr(0, 5'h17, 8'h01);
        step_to(192);
        wr(0, 5'h17, 8'hF2);
        check("res_old", res_filt, 8'h01);
        step_to(225);
        check("res_new", res_filt, 8'hF2);
        check("fc_hi_keep", fc_hi, 8'hA5);
        step_to(230);
        wr(0, 5'h05, 8'h55);
        wr(0, 5'h16, 8'h11);
        wr(0, 5'h16, 8'h22);
        step_to(257);
        check("fc_hi_last", fc_hi, 8'h22);
        check("cfg_keep", {fc_lo, res_filt, mode_vol}, {8'h07, 8'hF2, 8'h1F});
        step_to(262);
        v1_in = 12'h7FF;
        check("busy_mid", bsy, 1);
        rst = 1'b1;
        step(1);
        check("rst_v1_mid", v1, 0);
        check("rst_busy_mid", bsy, 0);
        check("rst_fc_mid", fc_hi, 0);
        rst = 1'b0;
        cyc = 0;
        step_to(32);
        check("post_iv32", iv, 0);
        step_to(33);
        check("post_iv33", iv, 1);
        check("post_v1", v1, 12'h7FF);
        rst2 = 1'b0;
        cyc = 0;
        step_to(15);
        check("b_iv15", iv2, 1);
        step_to(27);
        check("b_ovr27", ovr2, 0);
        step_to(28);
        check("b_ovr28", ovr2, 1);
        step_to(29);
        check("b_iv29", iv2, 0);
        check("b_busy29", bsy2, 0);
        step_to(43);
        check("b_iv43", iv2, 1);
        step_to(71);
        check("b_iv71", iv2, 1);
        wr(1, 5'h1F, 8'hAB);
        check("b_ovr_clr", ovr2, 0);
        step_to(83);
        check("b_ovr83", ovr2, 0);
        step_to(84);
        check("b_ovr84", ovr2, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
